// File: rtl/reg_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// reg_cfg_ctrl
// Host-side configuration controller. Accepts one read or write transaction at
// a time on a sel/ack host bus, decodes the byte address against the fixed
// register map and turns writes into a single-cycle one-hot write enable plus
// data toward the register block. Reads return the addressed register content.
//
// Optional build macro: CFG_CTRL_LOCK_EN
//   When defined, adds a write-lock bit at address 8'h10. Writing 8'hA5 there
//   sets the lock, and only reset clears it. While locked, register writes ack
//   with an error and no write enable. A read of 8'h10 returns the lock bit.
//   When undefined, 8'h10 is an ordinary miss.
//
// Ports:
//   clk                 rising-edge clock
//   rst                 asynchronous active-high reset
//   cfg_sel             host transaction request
//   cfg_wr              1 = write, 0 = read (sampled with cfg_sel)
//   cfg_addr            byte address
//   cfg_wdata           write data
//   cfg_ack             one-cycle transaction-complete pulse
//   cfg_err             error flag, valid with cfg_ack
//   cfg_rdata           read data, valid with cfg_ack on reads
//   wr_en               one-hot register write enable (upper bits always 0)
//   wr_data             write data toward the register block
//   reg_data_0..3       current register contents
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module reg_cfg_ctrl #(
   parameter int NUM_OF_REG = 4,
   parameter int W_WIDTH    = 8,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_sel,
   input  logic                  cfg_wr,
   input  logic [ADDR_WIDTH-1:0] cfg_addr,
   input  logic [W_WIDTH-1:0]    cfg_wdata,
   output logic                  cfg_ack,
   output logic                  cfg_err,
   output logic [W_WIDTH-1:0]    cfg_rdata,
   output logic [W_WIDTH-1:0]    wr_en,
   output logic [W_WIDTH-1:0]    wr_data,
   input  logic [W_WIDTH-1:0]    reg_data_0,
   input  logic [W_WIDTH-1:0]    reg_data_1,
   input  logic [W_WIDTH-1:0]    reg_data_2,
   input  logic [W_WIDTH-1:0]    reg_data_3
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      DECODE  = 3'd1,
      WRITE   = 3'd2,
      READ    = 3'd3,
      ACK     = 3'd4,
      RELEASE = 3'd5
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] ADDR_REG0 = ADDR_WIDTH'(8'h00);
   localparam logic [ADDR_WIDTH-1:0] ADDR_REG1 = ADDR_WIDTH'(8'h02);
   localparam logic [ADDR_WIDTH-1:0] ADDR_REG2 = ADDR_WIDTH'(8'h04);
   localparam logic [ADDR_WIDTH-1:0] ADDR_REG3 = ADDR_WIDTH'(8'h08);

   state_t                  state_r;
   logic                    wr_lat_r;
   logic [ADDR_WIDTH-1:0]   addr_lat_r;
   logic [W_WIDTH-1:0]      wdata_lat_r;

   logic [NUM_OF_REG-1:0]   hit_s;
   logic                    lock_hit_s;
   logic                    locked_s;
   state_t                  dec_next_s;
   logic                    dec_err_s;
   logic [W_WIDTH-1:0]      rd_mux_s;

   // One-hot register hit for a byte address; all zeros on a miss.
   function automatic logic [NUM_OF_REG-1:0] decode_hit(input logic [ADDR_WIDTH-1:0] addr);
      logic [NUM_OF_REG-1:0] hit;
      hit = {NUM_OF_REG{1'b0}};
      case (addr)
         ADDR_REG0: hit[0] = 1'b1;
         ADDR_REG1: hit[1] = 1'b1;
         ADDR_REG2: hit[2] = 1'b1;
         ADDR_REG3: hit[3] = 1'b1;
         default:   hit = {NUM_OF_REG{1'b0}};
      endcase
      return hit;
   endfunction

   // Register content selected by a one-hot hit vector.
   function automatic logic [W_WIDTH-1:0] select_reg(
      input logic [NUM_OF_REG-1:0] hit,
      input logic [W_WIDTH-1:0]    d0,
      input logic [W_WIDTH-1:0]    d1,
      input logic [W_WIDTH-1:0]    d2,
      input logic [W_WIDTH-1:0]    d3
   );
      logic [W_WIDTH-1:0] data;
      case (hit)
         4'b0001: data = d0;
         4'b0010: data = d1;
         4'b0100: data = d2;
         4'b1000: data = d3;
         default: data = {W_WIDTH{1'b0}};
      endcase
      return data;
   endfunction

   assign hit_s = decode_hit(addr_lat_r);

`ifdef CFG_CTRL_LOCK_EN
   localparam logic [ADDR_WIDTH-1:0] ADDR_LOCK = ADDR_WIDTH'(8'h10);
   localparam logic [W_WIDTH-1:0]    LOCK_KEY  = W_WIDTH'(8'hA5);

   logic lock_r;
   logic lock_set_s;

   assign lock_hit_s = (addr_lat_r == ADDR_LOCK);
   assign lock_set_s = lock_hit_s & wr_lat_r & (wdata_lat_r == LOCK_KEY);
   assign locked_s   = lock_r;

   // Sticky lock bit: set by the key write while decoding, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_r <= 1'b0;
      end else if ((state_r == DECODE) && lock_set_s) begin
         lock_r <= 1'b1;
      end else begin
         lock_r <= lock_r;
      end
   end
`else
   assign lock_hit_s = 1'b0;
   assign locked_s   = 1'b0;
`endif

   // Decode outcome of the latched transaction: next state and error flag.
   always_comb begin
      dec_next_s = ACK;
      dec_err_s  = 1'b1;
      if (|hit_s) begin
         if (!wr_lat_r) begin
            dec_next_s = READ;
            dec_err_s  = 1'b0;
         end else if (locked_s) begin
            dec_next_s = ACK;
            dec_err_s  = 1'b1;
         end else begin
            dec_next_s = WRITE;
            dec_err_s  = 1'b0;
         end
      end else if (lock_hit_s) begin
         // Lock register: writes complete straight away, reads go through READ.
         dec_next_s = wr_lat_r ? ACK : READ;
         dec_err_s  = 1'b0;
      end else begin
         dec_next_s = ACK;
         dec_err_s  = 1'b1;
      end
   end

   // Read data source for the READ state.
   always_comb begin
      if (lock_hit_s) begin
         rd_mux_s = {{(W_WIDTH-1){1'b0}}, locked_s};
      end else begin
         rd_mux_s = select_reg(hit_s, reg_data_0, reg_data_1, reg_data_2, reg_data_3);
      end
   end

   // Transaction FSM with registered host and register-block outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         wr_lat_r    <= 1'b0;
         addr_lat_r  <= {ADDR_WIDTH{1'b0}};
         wdata_lat_r <= {W_WIDTH{1'b0}};
         cfg_ack     <= 1'b0;
         cfg_err     <= 1'b0;
         cfg_rdata   <= {W_WIDTH{1'b0}};
         wr_en       <= {W_WIDTH{1'b0}};
         wr_data     <= {W_WIDTH{1'b0}};
      end else begin
         // Pulses default low; only the transitions into WRITE/ACK raise them.
         cfg_ack <= 1'b0;
         cfg_err <= 1'b0;
         wr_en   <= {W_WIDTH{1'b0}};
         case (state_r)
            IDLE: begin
               if (cfg_sel) begin
                  wr_lat_r    <= cfg_wr;
                  addr_lat_r  <= cfg_addr;
                  wdata_lat_r <= cfg_wdata;
                  state_r     <= DECODE;
               end
            end
            DECODE: begin
               state_r <= dec_next_s;
               if (dec_next_s == WRITE) begin
                  wr_en   <= {{(W_WIDTH-NUM_OF_REG){1'b0}}, hit_s};
                  wr_data <= wdata_lat_r;
               end else if (dec_next_s == ACK) begin
                  cfg_ack <= 1'b1;
                  cfg_err <= dec_err_s;
                  // A read miss returns zero; writes leave the last read data alone.
                  if (!wr_lat_r) begin
                     cfg_rdata <= {W_WIDTH{1'b0}};
                  end
               end
            end
            WRITE: begin
               state_r <= ACK;
               cfg_ack <= 1'b1;
            end
            READ: begin
               state_r   <= ACK;
               cfg_ack   <= 1'b1;
               cfg_rdata <= rd_mux_s;
            end
            ACK: begin
               state_r <= RELEASE;
            end
            RELEASE: begin
               // A held request must drop before another transaction can start.
               if (!cfg_sel) begin
                  state_r <= IDLE;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reg_cfg_ctrl
// Self-checking bench for reg_cfg_ctrl. A simple register block stand-in
// captures wr_en/wr_data and feeds reg_data_N back to the DUT. A transaction
// level model (register array, lock bit, last read/write data) predicts ack
// latency, error, read data and write-enable activity for every transaction.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_reg_cfg_ctrl;

`ifdef CFG_CTRL_LOCK_EN
   localparam bit LOCK_ON = 1'b1;
`else
   localparam bit LOCK_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_sel;
   logic       cfg_wr;
   logic [7:0] cfg_addr;
   logic [7:0] cfg_wdata;
   logic       cfg_ack;
   logic       cfg_err;
   logic [7:0] cfg_rdata;
   logic [7:0] wr_en;
   logic [7:0] wr_data;

   logic [7:0] regs [4] = '{8'h3C, 8'hC3, 8'h96, 8'h69};

   logic [7:0] mdl_reg [4] = '{8'h3C, 8'hC3, 8'h96, 8'h69};
   logic       mdl_lock  = 1'b0;
   logic [7:0] mdl_rdata = 8'h00;
   logic [7:0] mdl_wdata = 8'h00;

   int vectors     = 0;
   int miscompares = 0;

   reg_cfg_ctrl #(.NUM_OF_REG(4), .W_WIDTH(8), .ADDR_WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_sel    (cfg_sel),
      .cfg_wr     (cfg_wr),
      .cfg_addr   (cfg_addr),
      .cfg_wdata  (cfg_wdata),
      .cfg_ack    (cfg_ack),
      .cfg_err    (cfg_err),
      .cfg_rdata  (cfg_rdata),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .reg_data_0 (regs[0]),
      .reg_data_1 (regs[1]),
      .reg_data_2 (regs[2]),
      .reg_data_3 (regs[3])
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Register block stand-in: captures write data on the enabled register.
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (wr_en[i]) regs[i] <= wr_data;
      end
   end

   task automatic check(input string tag, input string name,
                        input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s/%s: observed %0h expected %0h", tag, name, obs, exp);
      end
   endtask

   function automatic int map_index(input logic [7:0] addr);
      case (addr)
         8'h00:   return 0;
         8'h02:   return 1;
         8'h04:   return 2;
         8'h08:   return 3;
         default: return -1;
      endcase
   endfunction

   // One host transaction: cfg_sel is held for 'hold' cycles after it is
   // sampled, other host inputs are scrambled after latching, and 12 cycles
   // of outputs are observed.
   task automatic run_txn(input string tag, input logic wr, input logic [7:0] addr,
                          input logic [7:0] data, input int hold);
      int         idx, exp_lat, ack_cnt, ack_cyc, wen_cnt, wen_cyc, err_out;
      logic       is_lock, exp_err, do_write, err_seen;
      logic [7:0] exp_rd, rd_seen, wen_val, wd_seen;

      idx     = map_index(addr);
      is_lock = LOCK_ON && (addr == 8'h10);
      if (idx >= 0 && !(wr && mdl_lock)) begin
         exp_lat = 3; exp_err = 1'b0;
      end else if (is_lock) begin
         exp_lat = wr ? 2 : 3; exp_err = 1'b0;
      end else begin
         exp_lat = 2; exp_err = 1'b1;
      end
      do_write = wr && (idx >= 0) && !mdl_lock;
      if (wr)            exp_rd = mdl_rdata;
      else if (idx >= 0) exp_rd = mdl_reg[idx];
      else if (is_lock)  exp_rd = {7'b0, mdl_lock};
      else               exp_rd = 8'h00;

      ack_cnt = 0; ack_cyc = 0; wen_cnt = 0; wen_cyc = 0; err_out = 0;
      err_seen = 1'b0; rd_seen = 8'h00; wen_val = 8'h00; wd_seen = 8'h00;

      @(negedge clk);
      cfg_sel = 1'b1; cfg_wr = wr; cfg_addr = addr; cfg_wdata = data;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (cfg_ack) begin
            ack_cnt++;
            if (ack_cnt == 1) begin
               ack_cyc = c; err_seen = cfg_err; rd_seen = cfg_rdata;
            end
         end else if (cfg_err) begin
            err_out++;
         end
         if (wr_en != 8'h00) begin
            wen_cnt++;
            if (wen_cnt == 1) begin
               wen_cyc = c; wen_val = wr_en; wd_seen = wr_data;
            end
         end
         if (c >= hold) begin
            cfg_sel = 1'b0;
         end else begin
            cfg_wr = 1'($urandom); cfg_addr = 8'($urandom); cfg_wdata = 8'($urandom);
         end
      end

      if (do_write) begin
         mdl_reg[idx] = data;
         mdl_wdata    = data;
      end
      if (is_lock && wr && data == 8'hA5) mdl_lock = 1'b1;
      if (!wr) mdl_rdata = exp_rd;

      check(tag, "ack_count", ack_cnt, 1);
      check(tag, "ack_latency", ack_cyc, exp_lat);
      check(tag, "err", err_seen, exp_err);
      check(tag, "rdata", rd_seen, exp_rd);
      check(tag, "err_outside_ack", err_out, 0);
      check(tag, "wr_en_pulses", wen_cnt, do_write ? 1 : 0);
      if (do_write) begin
         check(tag, "wr_en_value", wen_val, 8'h01 << idx);
         check(tag, "wr_en_cycle", wen_cyc, 2);
         check(tag, "wr_data_at_wr_en", wd_seen, data);
      end
      check(tag, "wr_data_hold", wr_data, mdl_wdata);
      check(tag, "reg_block", {regs[3], regs[2], regs[1], regs[0]},
            {mdl_reg[3], mdl_reg[2], mdl_reg[1], mdl_reg[0]});
   endtask

   initial begin
      logic [7:0] addr_list [6];
      logic [7:0] old3;
      logic [7:0] a;

      addr_list = '{8'h00, 8'h02, 8'h04, 8'h08, 8'h10, 8'h00};

      // Reset state
      rst = 1'b1; cfg_sel = 1'b0; cfg_wr = 1'b0; cfg_addr = 8'h00; cfg_wdata = 8'h00;
      @(negedge clk);
      check("reset", "outputs", {cfg_ack, cfg_err, cfg_rdata, wr_en, wr_data}, 26'h0);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("idle", "ack_wr_en", {cfg_ack, wr_en}, 9'h0);
      end

      // Directed transactions
      run_txn("wr_hit",   1'b1, 8'h04, 8'h5A, 1);
      run_txn("rd_hit",   1'b0, 8'h04, 8'h00, 1);
      run_txn("wr_miss",  1'b1, 8'h06, 8'hFF, 1);
      run_txn("rd_miss",  1'b0, 8'h01, 8'h00, 2);
      run_txn("held_sel", 1'b1, 8'h00, 8'h11, 10);
      run_txn("after_held", 1'b1, 8'h02, 8'h22, 3);
      run_txn("rd_after", 1'b0, 8'h02, 8'h00, 1);

      // Reset during the WRITE cycle of a write to reg3
      old3 = mdl_reg[3];
      @(negedge clk);
      cfg_sel = 1'b1; cfg_wr = 1'b1; cfg_addr = 8'h08; cfg_wdata = ~old3;
      @(negedge clk);
      @(negedge clk);
      check("rst_mid", "wr_en_before", wr_en, 8'h08);
      #1 rst = 1'b1;
      #1;
      check("rst_mid", "outputs_async", {cfg_ack, cfg_err, cfg_rdata, wr_en, wr_data}, 26'h0);
      @(negedge clk);
      cfg_sel = 1'b0;
      rst = 1'b0;
      mdl_lock = 1'b0; mdl_rdata = 8'h00; mdl_wdata = 8'h00;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rst_mid", "no_ack_no_wr", {cfg_ack, wr_en}, 9'h0);
      end
      check("rst_mid", "reg3_kept", regs[3], old3);

      // Lock register (a plain miss in the default build)
      run_txn("lock_bad_key", 1'b1, 8'h10, 8'h5C, 1);
      run_txn("lock_rd0",     1'b0, 8'h10, 8'h00, 1);
      run_txn("lock_set",     1'b1, 8'h10, 8'hA5, 1);
      run_txn("locked_wr",    1'b1, 8'h02, 8'h33, 1);
      run_txn("lock_rd1",     1'b0, 8'h10, 8'h00, 1);
      run_txn("locked_rd",    1'b0, 8'h02, 8'h00, 1);

      // Randomized transactions
      for (int n = 0; n < 40; n++) begin
         a = addr_list[$urandom_range(0, 5)];
         if ($urandom_range(0, 5) == 0) a = 8'($urandom);
         run_txn("random", 1'($urandom), a, 8'($urandom), $urandom_range(1, 10));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/reg_cfg_ctrl.md
Name: reg_cfg_ctrl

Overview:
Host-side configuration controller for the switch's config register block. It accepts single read/write transactions on a simple sel/ack host bus and decodes the byte address against the fixed register map. Writes are converted into a one-cycle one-hot write-enable plus data toward the register block. Reads are served from the register block outputs. Sits between the host/testbench config interface and the register block feeding the switch ports.

Parameters:
NUM_OF_REG, 4, number of config registers; fixed at 4 (address map below is hard-wired).
W_WIDTH, 8, data width; also the width of the wr_en vector.
ADDR_WIDTH, 8, host address width.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-high reset.
cfg_sel  input  1  host transaction request.
cfg_wr  input  1  1 = write, 0 = read; valid while cfg_sel=1.
cfg_addr  input  ADDR_WIDTH  byte address.
cfg_wdata  input  W_WIDTH  write data.
cfg_ack  output  1  one-cycle transaction-complete pulse.
cfg_err  output  1  error flag; valid only with cfg_ack.
cfg_rdata  output  W_WIDTH  read data.
wr_en  output  W_WIDTH  one-hot register write enable; bits [W_WIDTH-1:NUM_OF_REG] always 0.
wr_data  output  W_WIDTH  write data to the register block.
reg_data_0..reg_data_3  input  W_WIDTH each  current register contents.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Address map: reg0=8'h00, reg1=8'h02, reg2=8'h04, reg3=8'h08. Every other address is a miss.
- All outputs are registered. On reset: state=IDLE, cfg_ack=0, cfg_err=0, cfg_rdata=0, wr_en=0, wr_data=0. Reset clears wr_en immediately, mid-transaction included; no partial write completes.
- FSM states: IDLE, DECODE, WRITE, READ, ACK, RELEASE.
- IDLE: on cfg_sel=1, latch cfg_wr, cfg_addr and cfg_wdata, then go to DECODE. Host inputs are ignored after latching.
- DECODE, write hit: go to WRITE. Read hit: go to READ. Miss: go to ACK with err.
- WRITE: wr_en holds the hit bit for exactly one cycle and wr_data holds the latched data. The register captures on the WRITE→ACK edge. wr_data holds its value afterwards until the next write.
- READ: on exit, cfg_rdata is loaded from the addressed reg_data_N. Next state is ACK.
- ACK: cfg_ack=1 for one cycle. cfg_err=1 only for a miss. A read miss loads cfg_rdata=0. A write leaves cfg_rdata unchanged.
- RELEASE: wait for cfg_sel=0, then go to IDLE. A held cfg_sel never starts a second transaction.
- Latency, counted from the edge that samples cfg_sel=1 in IDLE:
  - write: wr_en high in cycle 2, cfg_ack in cycle 3.
  - read: cfg_ack in cycle 3, cfg_rdata valid with it.
  - miss: cfg_ack in cycle 2.
- If cfg_sel drops before ack, the latched transaction still completes and acks. RELEASE then exits immediately.
- cfg_ack and cfg_err are 0 in every state other than ACK.

Optional Feature:
Macro CFG_CTRL_LOCK_EN.
- Defined:
  - Adds a lock bit at address 8'h10, reset 0.
  - Writing 8'hA5 to 8'h10 sets the lock; only reset clears it. Any other write data to 8'h10 acks with no change and no error.
  - While locked, writes to reg0..reg3 ack with cfg_err=1 and wr_en stays 0.
  - Reads are unaffected. A read of 8'h10 returns {7'b0, lock}.
- Undefined: 8'h10 is a miss like any unmapped address, and no lock logic is present.

Test Plan:
- Reset check: assert rst mid-run → all outputs 0 asynchronously. Release rst and hold cfg_sel=0 → cfg_ack and wr_en stay 0.
- Write hit: write 8'h5A to 8'h04 → wr_en=8'b0000_0100 for exactly 1 cycle, wr_data=8'h5A, cfg_ack 1 cycle later with cfg_err=0. Then read 8'h04 → cfg_rdata=8'h5A with cfg_ack, 3 cycles after sel.
- Miss: write 8'hFF to 8'h06, and read 8'h01 → cfg_ack with cfg_err=1 two cycles after sel, wr_en never asserts, read returns cfg_rdata=0.
- Held sel: write 8'h11 to 8'h00 and keep cfg_sel=1 for 10 cycles → exactly one wr_en pulse and one cfg_ack. A second write after sel drops is accepted normally.
- Reset mid-write: assert rst during the WRITE cycle (write to 8'h08) → wr_en drops asynchronously, reg_data_3 keeps its old value, no cfg_ack.
- With CFG_CTRL_LOCK_EN: write 8'hA5 to 8'h10, then write 8'h33 to 8'h02 → cfg_err=1, wr_en=0. Read 8'h10 → 8'h01. Without the macro, the write to 8'h10 → cfg_err=1.
